// File: rtl/slice_cmd_gen_if.sv
// -----------------------------------------------------------------------------
// slice_cmd_gen_if
//
// Bundles every non-clock/reset signal of slice_cmd_gen:
//   op_*     : slice descriptor handshake from the host (valid/ready)
//   cmd_*    : command strobe and fields toward the slice engine
//   eng_*    : slice engine status (busy level, done pulse)
//   busy/done/error/err_code : generator status back to the host
//
// Modports:
//   slave  : the generator's view (slice_cmd_gen)
//   master : the surrounding system's view (host + engine)
// -----------------------------------------------------------------------------
interface slice_cmd_gen_if;

  // Descriptor handshake
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_src_base;
  logic [15:0] op_dst_base;
  logic [15:0] op_dim0;
  logic [15:0] op_dim1;
  logic [15:0] op_dim2;
  logic [15:0] op_dim3;
  logic [15:0] op_start;
  logic [15:0] op_end;
  logic [1:0]  op_elem_shift;

  // Engine command
  logic        cmd_valid;
  logic [15:0] cmd_src_base;
  logic [15:0] cmd_dst_base;
  logic [15:0] cmd_src_row_len;
  logic [15:0] cmd_dst_row_len;
  logic [15:0] cmd_start_offset;
  logic [15:0] cmd_num_rows;

  // Engine status
  logic        eng_busy;
  logic        eng_done;

  // Generator status
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  modport slave (
    input  op_valid, op_src_base, op_dst_base,
           op_dim0, op_dim1, op_dim2, op_dim3,
           op_start, op_end, op_elem_shift,
           eng_busy, eng_done,
    output op_ready,
           cmd_valid, cmd_src_base, cmd_dst_base,
           cmd_src_row_len, cmd_dst_row_len, cmd_start_offset, cmd_num_rows,
           busy, done, error, err_code
  );

  modport master (
    output op_valid, op_src_base, op_dst_base,
           op_dim0, op_dim1, op_dim2, op_dim3,
           op_start, op_end, op_elem_shift,
           eng_busy, eng_done,
    input  op_ready,
           cmd_valid, cmd_src_base, cmd_dst_base,
           cmd_src_row_len, cmd_dst_row_len, cmd_start_offset, cmd_num_rows,
           busy, done, error, err_code
  );

endinterface

// File: rtl/slice_cmd_gen.sv
// -----------------------------------------------------------------------------
// slice_cmd_gen
//
// Turns a 4-D slice descriptor (dims in elements, slice [start,end) on the
// innermost dim) into a single byte-oriented command for the slice engine.
// The descriptor is validated first (zero dims, bad range, arithmetic or SRAM
// span overflow); a rejected op completes immediately with an error code and
// never reaches the engine.
//
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slice_cmd_gen_if.slave
//     op_*      descriptor in (valid/ready, accepted only while idle)
//     cmd_*     command out to the engine, fields held from ISSUE to WAIT,
//               zero while idle
//     eng_busy  engine busy level (holds the command back)
//     eng_done  engine completion pulse (only observed while waiting)
//     busy      high whenever an op is in flight
//     done      one-cycle completion pulse, success or error
//     error, err_code  result of the last op, held until the next accept
//                      (0 ok, 1 bad range, 2 zero dim, 3 overflow)
//
// Parameter:
//   SRAM0_AW : SRAM0 address width; source and destination spans must end at
//              or below 2**SRAM0_AW bytes.
//
// Timeline of a successful op accepted in cycle T:
//   T+1 MUL1, T+2 MUL2, T+3 CHECK, T+4 ISSUE (cmd_valid if engine idle),
//   then WAIT until eng_done, then one FIN cycle with done=1.
// -----------------------------------------------------------------------------
module slice_cmd_gen #(
  parameter int SRAM0_AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  slice_cmd_gen_if.slave bus
);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ZERO  = 2'd2;
  localparam logic [1:0] ERR_OVF   = 2'd3;

  // First byte address past the end of SRAM0.
  localparam logic [32:0] SPAN_LIMIT = 33'd1 << SRAM0_AW;

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    MUL2,
    CHECK,
    ISSUE,
    WAIT,
    FIN
  } state_t;

  state_t state_q;
  state_t state_d;

  // Element count scaled to bytes; kept 18 bits wide so a shift that
  // escapes the 16-bit command field is visible in bits [17:16].
  function automatic logic [17:0] scale_len(input logic [15:0] elems,
                                            input logic [1:0]  shift);
    return {2'b00, elems} << shift;
  endfunction

  function automatic logic len_ovf(input logic [17:0] len);
    return |len[17:16];
  endfunction

  // base + rows*row_len, wide enough that nothing wraps before comparing
  // against SPAN_LIMIT.
  function automatic logic [32:0] span_end(input logic [15:0] base,
                                           input logic [15:0] rows,
                                           input logic [15:0] row_len);
    logic [31:0] span;
    span = {16'd0, rows} * {16'd0, row_len};
    return {17'd0, base} + {1'b0, span};
  endfunction

  // Descriptor registers
  logic [15:0] src_base_p0;
  logic [15:0] dst_base_p0;
  logic [15:0] dim0_p0;
  logic [15:0] dim1_p0;
  logic [15:0] dim2_p0;
  logic [15:0] dim3_p0;
  logic [15:0] start_p0;
  logic [15:0] end_p0;
  logic [1:0]  shift_p0;

  // Row-count products
  logic [31:0] prod_p1;
  logic [31:0] rows_prod;
  logic [15:0] rows_p2;
  logic        ovf_rows_p2;

  // Check-stage combinational results
  logic [15:0] range_len;
  logic [17:0] src_len_w;
  logic [17:0] dst_len_w;
  logic [17:0] start_off_w;
  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        zero_dim;
  logic        bad_range;
  logic        any_ovf;

  // Registered command and status
  logic [15:0] cmd_src_base_q;
  logic [15:0] cmd_dst_base_q;
  logic [15:0] cmd_src_row_len_q;
  logic [15:0] cmd_dst_row_len_q;
  logic [15:0] cmd_start_offset_q;
  logic [15:0] cmd_num_rows_q;
  logic        error_q;
  logic [1:0]  err_code_q;

  logic        accept;

  assign accept = bus.op_valid && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // p0: descriptor capture (only on accept; ignored while busy)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      src_base_p0 <= bus.op_src_base;
      dst_base_p0 <= bus.op_dst_base;
      dim0_p0     <= bus.op_dim0;
      dim1_p0     <= bus.op_dim1;
      dim2_p0     <= bus.op_dim2;
      dim3_p0     <= bus.op_dim3;
      start_p0    <= bus.op_start;
      end_p0      <= bus.op_end;
      shift_p0    <= bus.op_elem_shift;
    end
  end

  // ---------------------------------------------------------------------------
  // p1: dim0*dim1 (MUL1)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == MUL1) begin
      prod_p1 <= {16'd0, dim0_p0} * {16'd0, dim1_p0};
    end
  end

  // ---------------------------------------------------------------------------
  // p2: rows = p1[15:0]*dim2 (MUL2); any upper bits mean rows does not fit
  // ---------------------------------------------------------------------------
  assign rows_prod = {16'd0, prod_p1[15:0]} * {16'd0, dim2_p0};

  always_ff @(posedge clk) begin
    if (state_q == MUL2) begin
      rows_p2     <= rows_prod[15:0];
      ovf_rows_p2 <= (|prod_p1[31:16]) | (|rows_prod[31:16]);
    end
  end

  // ---------------------------------------------------------------------------
  // CHECK: byte lengths, spans and error classification
  // ---------------------------------------------------------------------------
  // range_len wraps when end<start, but that case is already a range error
  // and takes precedence over any overflow it would produce.
  assign range_len   = end_p0 - start_p0;
  assign src_len_w   = scale_len(dim3_p0, shift_p0);
  assign dst_len_w   = scale_len(range_len, shift_p0);
  assign start_off_w = scale_len(start_p0, shift_p0);

  assign src_end = span_end(src_base_p0, rows_p2, src_len_w[15:0]);
  assign dst_end = span_end(dst_base_p0, rows_p2, dst_len_w[15:0]);

  assign zero_dim  = (dim0_p0 == 16'd0) || (dim1_p0 == 16'd0) ||
                     (dim2_p0 == 16'd0) || (dim3_p0 == 16'd0);
  assign bad_range = (end_p0 <= start_p0) || (end_p0 > dim3_p0);
  assign any_ovf   = ovf_rows_p2 || len_ovf(src_len_w) || len_ovf(dst_len_w) ||
                     len_ovf(start_off_w) ||
                     (src_end > SPAN_LIMIT) || (dst_end > SPAN_LIMIT);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake/status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    bus.op_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.done      = 1'b0;

    case (state_q)
      IDLE: begin
        bus.op_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.op_valid) begin
          state_d = MUL1;
        end
      end
      MUL1:  state_d = MUL2;
      MUL2:  state_d = CHECK;
      CHECK: begin
        if (zero_dim || bad_range || any_ovf) begin
          state_d = FIN;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Hold the strobe back while the engine is still busy.
        if (!bus.eng_busy) begin
          bus.cmd_valid = 1'b1;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (bus.eng_done) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command fields and result status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_src_base_q     <= 16'd0;
      cmd_dst_base_q     <= 16'd0;
      cmd_src_row_len_q  <= 16'd0;
      cmd_dst_row_len_q  <= 16'd0;
      cmd_start_offset_q <= 16'd0;
      cmd_num_rows_q     <= 16'd0;
      error_q            <= 1'b0;
      err_code_q         <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_valid) begin
            error_q    <= 1'b0;
            err_code_q <= ERR_OK;
          end
        end
        CHECK: begin
          if (zero_dim) begin
            error_q    <= 1'b1;
            err_code_q <= ERR_ZERO;
          end else if (bad_range) begin
            error_q    <= 1'b1;
            err_code_q <= ERR_RANGE;
          end else if (any_ovf) begin
            error_q    <= 1'b1;
            err_code_q <= ERR_OVF;
          end else begin
            cmd_src_base_q     <= src_base_p0;
            cmd_dst_base_q     <= dst_base_p0;
            cmd_src_row_len_q  <= src_len_w[15:0];
            cmd_dst_row_len_q  <= dst_len_w[15:0];
            cmd_start_offset_q <= start_off_w[15:0];
            cmd_num_rows_q     <= rows_p2;
          end
        end
        WAIT: begin
          if (bus.eng_done) begin
            error_q    <= 1'b0;
            err_code_q <= ERR_OK;
          end
        end
        FIN: begin
          // Leaving for IDLE: command fields read as zero while idle.
          cmd_src_base_q     <= 16'd0;
          cmd_dst_base_q     <= 16'd0;
          cmd_src_row_len_q  <= 16'd0;
          cmd_dst_row_len_q  <= 16'd0;
          cmd_start_offset_q <= 16'd0;
          cmd_num_rows_q     <= 16'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_src_base     = cmd_src_base_q;
  assign bus.cmd_dst_base     = cmd_dst_base_q;
  assign bus.cmd_src_row_len  = cmd_src_row_len_q;
  assign bus.cmd_dst_row_len  = cmd_dst_row_len_q;
  assign bus.cmd_start_offset = cmd_start_offset_q;
  assign bus.cmd_num_rows     = cmd_num_rows_q;
  assign bus.error            = error_q;
  assign bus.err_code         = err_code_q;

endmodule

// File: tb/tb_slice_cmd_gen.sv
// -----------------------------------------------------------------------------
// tb_slice_cmd_gen
//
// Directed bench for slice_cmd_gen. A descriptor-level model computes the
// expected command fields and result code of each accepted op from plain
// integer arithmetic; a per-cycle compare process checks the DUT against it,
// and directed sequences pin latencies and literal field values.
// -----------------------------------------------------------------------------
module tb_slice_cmd_gen;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  slice_cmd_gen_if bus ();

  slice_cmd_gen #(.SRAM0_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic [15:0] st;
    logic [15:0] en;
    logic [1:0]  sh;
  } op_t;

  typedef struct {
    int     code;
    longint src_len;
    longint dst_len;
    longint start_off;
    longint rows;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  op_t  cur_op;
  exp_t cur_exp;
  logic       last_err;
  logic [1:0] last_code;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(input int src, input int dst, input int d0, input int d1,
                                input int d2, input int d3, input int st, input int en,
                                input int sh);
    op_t o;
    o.src = 16'(src); o.dst = 16'(dst);
    o.d0 = 16'(d0); o.d1 = 16'(d1); o.d2 = 16'(d2); o.d3 = 16'(d3);
    o.st = 16'(st); o.en = 16'(en); o.sh = 2'(sh);
    return o;
  endfunction

  // Descriptor-level reference: what the command must be, or why the op fails.
  function automatic exp_t model(input op_t o);
    exp_t   e;
    longint lim;
    lim         = longint'(1) << AW;
    e.rows      = longint'(o.d0) * longint'(o.d1) * longint'(o.d2);
    e.src_len   = longint'(o.d3) << o.sh;
    e.dst_len   = (longint'(o.en) - longint'(o.st)) << o.sh;
    e.start_off = longint'(o.st) << o.sh;
    if (o.d0 == 0 || o.d1 == 0 || o.d2 == 0 || o.d3 == 0)
      e.code = 2;
    else if (o.en <= o.st || o.en > o.d3)
      e.code = 1;
    else if (e.rows > 65535 || e.src_len > 65535 || e.dst_len > 65535 ||
             e.start_off > 65535 ||
             longint'(o.src) + e.rows * e.src_len > lim ||
             longint'(o.dst) + e.rows * e.dst_len > lim)
      e.code = 3;
    else
      e.code = 0;
    return e;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      last_err  = 1'b0;
      last_code = 2'd0;
    end else begin
      chk("op_ready_vs_busy", 64'(bus.op_ready), 64'(!bus.busy));
      if (!bus.busy) begin
        chk("idle_cmd_zero", 64'(|{bus.cmd_src_base, bus.cmd_dst_base, bus.cmd_src_row_len,
                                   bus.cmd_dst_row_len, bus.cmd_start_offset, bus.cmd_num_rows,
                                   bus.cmd_valid, bus.done}), 64'(0));
        chk("err_hold", 64'({bus.error, bus.err_code}), 64'({last_err, last_code}));
      end
      if (bus.cmd_valid) begin
        chk("cmd_valid_eng_idle", 64'(bus.eng_busy), 64'(0));
        chk("cmd_valid_op_ok", 64'(cur_exp.code), 64'(0));
        chk("cmd_src_base", 64'(bus.cmd_src_base), 64'(cur_op.src));
        chk("cmd_dst_base", 64'(bus.cmd_dst_base), 64'(cur_op.dst));
        chk("cmd_src_row_len", 64'(bus.cmd_src_row_len), 64'(cur_exp.src_len));
        chk("cmd_dst_row_len", 64'(bus.cmd_dst_row_len), 64'(cur_exp.dst_len));
        chk("cmd_start_offset", 64'(bus.cmd_start_offset), 64'(cur_exp.start_off));
        chk("cmd_num_rows", 64'(bus.cmd_num_rows), 64'(cur_exp.rows));
      end
      if (bus.done) begin
        chk("done_error", 64'(bus.error), 64'(cur_exp.code != 0));
        chk("done_err_code", 64'(bus.err_code), 64'(cur_exp.code));
        last_err  = (cur_exp.code != 0);
        last_code = 2'(cur_exp.code);
      end
      if (bus.op_valid && bus.op_ready) begin
        cur_op = mk_op(int'(bus.op_src_base), int'(bus.op_dst_base), int'(bus.op_dim0),
                       int'(bus.op_dim1), int'(bus.op_dim2), int'(bus.op_dim3),
                       int'(bus.op_start), int'(bus.op_end), int'(bus.op_elem_shift));
        cur_exp = model(cur_op);
      end
    end
  end

  task automatic drive_op(input op_t o);
    bus.op_src_base   = o.src;
    bus.op_dst_base   = o.dst;
    bus.op_dim0       = o.d0;
    bus.op_dim1       = o.d1;
    bus.op_dim2       = o.d2;
    bus.op_dim3       = o.d3;
    bus.op_start      = o.st;
    bus.op_end        = o.en;
    bus.op_elem_shift = o.sh;
  endtask

  // Runs one op from an idle DUT (called at posedge+1). Cycle n counts from
  // the accept cycle (n=0). eng_busy is high for n<=busy_until, a stray
  // eng_done is pulsed at spurious_n, a rejected descriptor is offered at
  // junk_n, and the engine completes the cycle after cmd_valid.
  task automatic run_op(input op_t o, input int busy_until, input int spurious_n,
                        input int junk_n, output int cv_n, output int done_n,
                        output logic [95:0] fields, output logic [2:0] result);
    logic [95:0] now;
    cv_n   = -1;
    done_n = -1;
    fields = '0;
    result = '0;
    drive_op(o);
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      bus.eng_busy = (n <= busy_until);
      bus.eng_done = (n == spurious_n) || (cv_n > 0 && n == cv_n + 1);
      if (n == junk_n) begin
        drive_op(mk_op(16'h00AA, 16'h00BB, 7, 7, 7, 50, 9, 20, 1));
        bus.op_valid = 1'b1;
      end else begin
        bus.op_valid = 1'b0;
      end
      @(negedge clk);
      now = {bus.cmd_src_base, bus.cmd_dst_base, bus.cmd_src_row_len,
             bus.cmd_dst_row_len, bus.cmd_start_offset, bus.cmd_num_rows};
      if (bus.cmd_valid && cv_n < 0) begin
        cv_n   = n;
        fields = now;
      end else if (cv_n > 0 && bus.busy) begin
        chk("cmd_stable", 64'(now != fields), 64'(0));
      end
      if (bus.done) begin
        done_n = n;
        result = {bus.error, bus.err_code};
        break;
      end
      @(posedge clk); #1;
    end
    bus.eng_busy = 1'b0;
    bus.eng_done = 1'b0;
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_fields(input string tag, input logic [95:0] f,
                              input int src, input int dst, input int sl,
                              input int dl, input int so, input int nr);
    chk({tag, "_src_base"},   64'(f[95:80]), 64'(src));
    chk({tag, "_dst_base"},   64'(f[79:64]), 64'(dst));
    chk({tag, "_src_len"},    64'(f[63:48]), 64'(sl));
    chk({tag, "_dst_len"},    64'(f[47:32]), 64'(dl));
    chk({tag, "_start_off"},  64'(f[31:16]), 64'(so));
    chk({tag, "_num_rows"},   64'(f[15:0]),  64'(nr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op_t         basic;
    op_t         o;
    exp_t        e;
    int          cv;
    int          dn;
    logic [95:0] f;
    logic [2:0]  r;

    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.eng_busy = 1'b0;
    bus.eng_done = 1'b0;
    drive_op(mk_op(0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_op_ready", 64'(bus.op_ready), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_cmd_valid", 64'(bus.cmd_valid), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_error", 64'({bus.error, bus.err_code}), 64'(0));
    @(posedge clk); #1;

    // Basic op, with a descriptor offered mid-op that must be ignored
    basic = mk_op(16'h0100, 16'h0800, 1, 2, 3, 8, 2, 6, 0);
    e = model(basic);
    chk("model_basic_src_len", 64'(e.src_len), 64'(8));
    chk("model_basic_dst_len", 64'(e.dst_len), 64'(4));
    chk("model_basic_rows", 64'(e.rows), 64'(6));
    chk("model_basic_code", 64'(e.code), 64'(0));
    run_op(basic, 0, 0, 2, cv, dn, f, r);
    chk("basic_cv_latency", 64'(cv), 64'(4));
    chk("basic_done_latency", 64'(dn), 64'(6));
    check_fields("basic", f, 16'h0100, 16'h0800, 8, 4, 2, 6);
    chk("basic_result", 64'(r), 64'(0));

    // Element shift
    o = mk_op(16'h0000, 16'h1000, 1, 1, 1, 10, 3, 5, 2);
    run_op(o, 0, 0, 0, cv, dn, f, r);
    chk("shift_cv_latency", 64'(cv), 64'(4));
    check_fields("shift", f, 16'h0000, 16'h1000, 40, 8, 12, 1);
    chk("shift_result", 64'(r), 64'(0));

    // Bad range: start == end
    o = mk_op(0, 0, 1, 1, 1, 8, 5, 5, 0);
    chk("model_range_code", 64'(model(o).code), 64'(1));
    run_op(o, 0, 0, 0, cv, dn, f, r);
    chk("range_no_cmd", 64'(cv), -64'sd1);
    chk("range_done_latency", 64'(dn), 64'(4));
    chk("range_result", 64'(r), 64'({1'b1, 2'd1}));

    // Zero dim beats a bad range
    o = mk_op(0, 0, 1, 1, 0, 8, 6, 2, 0);
    chk("model_zero_code", 64'(model(o).code), 64'(2));
    run_op(o, 0, 0, 0, cv, dn, f, r);
    chk("zero_no_cmd", 64'(cv), -64'sd1);
    chk("zero_result", 64'(r), 64'({1'b1, 2'd2}));

    // Row count overflow
    o = mk_op(0, 0, 256, 256, 1, 1, 0, 1, 0);
    chk("model_rows_ovf_code", 64'(model(o).code), 64'(3));
    run_op(o, 0, 0, 0, cv, dn, f, r);
    chk("rows_ovf_done_latency", 64'(dn), 64'(4));
    chk("rows_ovf_result", 64'(r), 64'({1'b1, 2'd3}));

    // Source span past the end of SRAM0
    o = mk_op(16'hFF00, 0, 1, 1, 1, 16'h0200, 0, 1, 0);
    chk("model_span_code", 64'(model(o).code), 64'(3));
    run_op(o, 0, 0, 0, cv, dn, f, r);
    chk("span_no_cmd", 64'(cv), -64'sd1);
    chk("span_result", 64'(r), 64'({1'b1, 2'd3}));

    // Shift pushes the row length past 16 bits
    o = mk_op(0, 0, 1, 1, 1, 16'h8000, 0, 1, 1);
    run_op(o, 0, 0, 0, cv, dn, f, r);
    chk("len_ovf_result", 64'(r), 64'({1'b1, 2'd3}));

    // Back-pressure: engine busy through n=8, stray eng_done in ISSUE
    run_op(basic, 8, 6, 0, cv, dn, f, r);
    chk("bp_cv_when_busy_falls", 64'(cv), 64'(9));
    chk("bp_done_latency", 64'(dn), 64'(11));
    chk("bp_result", 64'(r), 64'(0));

    // Reset while waiting on the engine
    drive_op(basic);
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rw_cmd_valid_issue", 64'(bus.cmd_valid), 64'(1));
    @(posedge clk); #1;
    bus.eng_busy = 1'b1;
    @(negedge clk);
    chk("rw_busy_in_wait", 64'(bus.busy), 64'(1));
    rst          = 1'b1;
    bus.eng_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_busy", 64'(bus.busy), 64'(0));
    chk("rw_cmd_valid", 64'(bus.cmd_valid), 64'(0));
    chk("rw_op_ready", 64'(bus.op_ready), 64'(1));
    chk("rw_cmd_fields", 64'(|{bus.cmd_src_base, bus.cmd_src_row_len, bus.cmd_num_rows}), 64'(0));
    @(posedge clk); #1;

    // First op after reset behaves like the first op after power-up
    run_op(basic, 0, 0, 0, cv, dn, f, r);
    chk("post_rst_cv_latency", 64'(cv), 64'(4));
    chk("post_rst_done_latency", 64'(dn), 64'(6));
    check_fields("post_rst", f, 16'h0100, 16'h0800, 8, 4, 2, 6);
    chk("post_rst_result", 64'(r), 64'(0));

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_cmd_gen.md
SLICE_CMD_GEN -- requirements
Module: slice_cmd_gen

Interface
REQ-001 SHALL have parameter SRAM0_AW, default 16, SRAM0 address width used for span checking.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 op_valid  in  1  slice op descriptor valid.
REQ-006 op_ready  out  1  descriptor accepted when op_valid&op_ready.
REQ-007 op_src_base, op_dst_base  in  16 each  byte base addresses.
REQ-008 op_dim0, op_dim1, op_dim2  in  16 each  outer dims, in elements.
REQ-009 op_dim3  in  16  innermost (sliced) dim, in elements.
REQ-010 op_start, op_end  in  16 each  slice range [start,end) on dim3, in elements.
REQ-011 op_elem_shift  in  2  element size = 1<<op_elem_shift bytes.
REQ-012 cmd_valid  out  1  command strobe to slice engine.
REQ-013 cmd_src_base, cmd_dst_base, cmd_src_row_len, cmd_dst_row_len, cmd_start_offset, cmd_num_rows  out  16 each  engine command fields, in bytes or rows.
REQ-014 eng_busy  in  1  slice engine busy.
REQ-015 eng_done  in  1  slice engine one-cycle completion pulse.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse, for success or error.
REQ-018 error  out  1  valid with done; 1 means the op was rejected.
REQ-019 err_code  out  2  0 = ok, 1 = bad range, 2 = zero dim, 3 = overflow.

Function
REQ-020 FSM SHALL have states IDLE, MUL1, MUL2, CHECK, ISSUE, WAIT, FIN.
REQ-021 op_ready SHALL be 1 only in IDLE. On accept, all op_* fields SHALL be registered and the FSM SHALL go to MUL1.
REQ-022 MUL1: p1 = dim0*dim1, 32-bit, registered.
REQ-023 MUL2: rows = p1[15:0]*dim2, 32-bit, registered. Set ovf_rows if p1[31:16]!=0 or the product's [31:16]!=0.
REQ-024 CHECK: src_row_len = dim3<<shift; dst_row_len = (end-start)<<shift; start_offset = start<<shift. Each is computed at 18 bits; a nonzero bit above [15] sets overflow.
REQ-025 CHECK span rule: span = rows[15:0]*src_row_len. Overflow if src_base+span > 2^SRAM0_AW or dst_base + rows*dst_row_len > 2^SRAM0_AW.
REQ-026 CHECK error precedence, first match wins:
  - zero dim (any dim0..dim3 == 0) -> code 2
  - end<=start or end>dim3 -> code 1
  - any overflow -> code 3
  - otherwise -> ISSUE
  Any error SHALL go to FIN with error=1.
REQ-027 ISSUE: cmd_valid=1 only when eng_busy==0; the FSM then goes to WAIT. If eng_busy==1, it SHALL stay in ISSUE with cmd_valid=0.
REQ-028 cmd_* fields SHALL be registered, SHALL be stable from ISSUE through WAIT, and SHALL be 0 in IDLE.
REQ-029 WAIT: on eng_done -> FIN with error=0, err_code=0. eng_done SHALL be ignored in all other states.
REQ-030 FIN SHALL last one cycle (done=1) -> IDLE. error/err_code SHALL hold their value until the next accept.
REQ-031 Success latency: accept at T -> cmd_valid at T+4, when the engine is idle.
REQ-032 op_valid during busy SHALL NOT be accepted and SHALL NOT alter any registered field.

Reset
REQ-033 On rst, FSM SHALL go to IDLE.
REQ-034 On rst, every output SHALL be 0 except op_ready=1, including when rst is asserted mid-op (any state).
REQ-035 The first op after rst SHALL behave identically to the first op after power-up.

Verification
REQ-036 Basic op: dims {1,2,3,8}, start=2, end=6, shift=0, bases 0x0100/0x0800.
  - cmd_valid at T+4
  - src_row_len=8, dst_row_len=4, start_offset=2, num_rows=6
  - eng_done pulse -> done=1, error=0
REQ-037 Element shift: shift=2, dim3=10, start=3, end=5.
  - src_row_len=40, dst_row_len=8, start_offset=12
REQ-038 Bad range: start=5, end=5 -> done at T+4, error=1, err_code=1, cmd_valid never asserted.
  - Also dim2=0 with end<start -> err_code=2 (precedence).
REQ-039 Overflow:
  - dims {256,256,1,1} -> err_code=3
  - src_base=0xFF00, 1 row, src_row_len=0x200 -> err_code=3
REQ-040 Back-pressure: eng_busy held high 5 cycles after CHECK.
  - cmd_valid=0 throughout, FSM stays in ISSUE
  - cmd_valid asserts the cycle eng_busy falls
  - spurious eng_done in ISSUE is ignored
REQ-041 Reset in WAIT: next cycle busy=0, cmd_valid=0, op_ready=1.
  - A new op then completes normally.
